updown_counter_pload: RTL and testbench

//  Parametrised up/down counter with parallel load, count enable and a programmable modulus.

---
 rtl/updown_counter_pload.sv | 88 ++++++++
 tb/tb_updown_counter_pload.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_pload.sv
// updown_counter_pload
//   Parametrised up/down counter with parallel load, count enable and a
//   runtime terminal value (count range 0..max_i inclusive).
//
//   Parameters
//     BUS_WIDTH   : width of counter, data_i and max_i (>= 2)
//     SATURATE    : 0 = wrap at the bounds, 1 = hold at the bounds
//     RESET_VALUE : data_o value while / after reset
//
//   Ports
//     Clk     : clock, rising edge
//     Rst_n   : asynchronous active-low reset
//     en_i    : count enable
//     load_i  : parallel load (priority over en_i)
//     d_i     : direction, 0 = up, 1 = down
//     data_i  : parallel load value (clamped to max_i)
//     max_i   : terminal value
//     data_o  : current count (registered)
//     cout    : combinational terminal count for the step this cycle
//     wrap_o  : registered one-cycle pulse after a wrapping edge
module updown_counter_pload #(
    parameter int unsigned              BUS_WIDTH   = 8,
    parameter int unsigned              SATURATE    = 0,
    parameter logic [BUS_WIDTH-1:0]     RESET_VALUE = '0
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 en_i,
    input  logic                 load_i,
    input  logic                 d_i,
    input  logic [BUS_WIDTH-1:0] data_i,
    input  logic [BUS_WIDTH-1:0] max_i,
    output logic [BUS_WIDTH-1:0] data_o,
    output logic                 cout,
    output logic                 wrap_o
);

    localparam bit SAT = (SATURATE != 0);

    logic                 in_range;
    logic                 at_top;
    logic                 at_bot;
    logic [BUS_WIDTH-1:0] cnt_next;
    logic                 wrap_next;

    assign in_range = (data_o <= max_i);
    assign at_top   = (data_o == max_i);
    assign at_bot   = (data_o == '0);

    // Terminal count only for in-range steps; out-of-range recovery is silent.
    assign cout = en_i & ~load_i & in_range &
                  ((~d_i & at_top) | (d_i & at_bot));

    // cout is already zero on load/hold, so it alone decides the pulse.
    assign wrap_next = cout & ~SAT;

    always_comb begin
        cnt_next = data_o;
        if (load_i) begin
            cnt_next = (data_i > max_i) ? max_i : data_i;
        end else if (en_i) begin
            if (in_range) begin
                if (!d_i) begin
                    if (at_top) cnt_next = SAT ? max_i : '0;
                    else        cnt_next = data_o + 1'b1;
                end else begin
                    if (at_bot) cnt_next = SAT ? '0 : max_i;
                    else        cnt_next = data_o - 1'b1;
                end
            end else begin
                // Above the terminal value: up restarts (or clamps), down clamps.
                if (!d_i) cnt_next = SAT ? max_i : '0;
                else      cnt_next = max_i;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            data_o <= RESET_VALUE;
            wrap_o <= 1'b0;
        end else begin
            data_o <= cnt_next;
            wrap_o <= wrap_next;
        end
    end

endmodule

// File: tb/tb_updown_counter_pload.sv
module tb_updown_counter_pload;

    logic       Clk;
    logic       Rst_n;
    logic       en_i;
    logic       load_i;
    logic       d_i;
    logic [7:0] data_i;
    logic [7:0] max_i;
    logic [7:0] data_w, data_s;
    logic       cout_w, cout_s;
    logic       wrap_w, wrap_s;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         idx;
        logic [7:0] dw;
        logic       cw;
        logic       ww;
        logic [7:0] ds;
        logic       cs;
        logic       ws;
    } exp_t;

    exp_t sb[$];
    int   vec_n = 0;

    updown_counter_pload #(
        .BUS_WIDTH   (8),
        .SATURATE    (0),
        .RESET_VALUE (8'h00)
    ) u_wrap (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .en_i   (en_i),
        .load_i (load_i),
        .d_i    (d_i),
        .data_i (data_i),
        .max_i  (max_i),
        .data_o (data_w),
        .cout   (cout_w),
        .wrap_o (wrap_w)
    );

    updown_counter_pload #(
        .BUS_WIDTH   (8),
        .SATURATE    (1),
        .RESET_VALUE (8'h11)
    ) u_sat (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .en_i   (en_i),
        .load_i (load_i),
        .d_i    (d_i),
        .data_i (data_i),
        .max_i  (max_i),
        .data_o (data_s),
        .cout   (cout_s),
        .wrap_o (wrap_s)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Monitor: outputs are sampled every falling edge while expectations are queued.
    always @(negedge Clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("wrap.data_o", e.idx, data_w, e.dw);
            chk("wrap.cout",   e.idx, {7'd0, cout_w}, {7'd0, e.cw});
            chk("wrap.wrap_o", e.idx, {7'd0, wrap_w}, {7'd0, e.ww});
            chk("sat.data_o",  e.idx, data_s, e.ds);
            chk("sat.cout",    e.idx, {7'd0, cout_s}, {7'd0, e.cs});
            chk("sat.wrap_o",  e.idx, {7'd0, wrap_s}, {7'd0, e.ws});
        end
    end

    // Drive one cycle of inputs and queue what both counters show during that cycle
    // (data_o/wrap_o from the previous edge, cout from these inputs).
    task automatic step(input logic ld, input logic en, input logic d,
                        input logic [7:0] data, input logic [7:0] mx,
                        input logic [7:0] dw, input logic cw, input logic ww,
                        input logic [7:0] ds, input logic cs, input logic ws);
        exp_t e;
        @(posedge Clk);
        #1;
        load_i = ld;
        en_i   = en;
        d_i    = d;
        data_i = data;
        max_i  = mx;
        e.idx = vec_n;
        e.dw = dw; e.cw = cw; e.ww = ww;
        e.ds = ds; e.cs = cs; e.ws = ws;
        sb.push_back(e);
        vec_n++;
    endtask

    initial begin
        Rst_n  = 1'b0;
        en_i   = 1'b0;
        load_i = 1'b0;
        d_i    = 1'b0;
        data_i = 8'h00;
        max_i  = 8'h05;
        repeat (2) @(posedge Clk);
        #1 Rst_n = 1'b1;

        //     ld en d  data   max    | wrap: data cout wrap | sat: data cout wrap
        // Up wrap, max 5, load 3
        step(1, 0, 0, 8'd3,  8'd5,    8'h00, 0, 0,  8'h11, 0, 0);
        step(0, 1, 0, 8'd0,  8'd5,    8'd3,  0, 0,  8'd3,  0, 0);
        step(0, 1, 0, 8'd0,  8'd5,    8'd4,  0, 0,  8'd4,  0, 0);
        step(0, 1, 0, 8'd0,  8'd5,    8'd5,  1, 0,  8'd5,  1, 0);
        step(0, 1, 0, 8'd0,  8'd5,    8'd0,  0, 1,  8'd5,  1, 0);
        step(0, 0, 0, 8'd0,  8'd5,    8'd1,  0, 0,  8'd5,  0, 0);
        // Down wrap, max 9, load 1
        step(1, 0, 0, 8'd1,  8'd9,    8'd1,  0, 0,  8'd5,  0, 0);
        step(0, 1, 1, 8'd0,  8'd9,    8'd1,  0, 0,  8'd1,  0, 0);
        step(0, 1, 1, 8'd0,  8'd9,    8'd0,  1, 0,  8'd0,  1, 0);
        step(0, 1, 1, 8'd0,  8'd9,    8'd9,  0, 1,  8'd0,  1, 0);
        step(0, 0, 1, 8'd0,  8'd9,    8'd8,  0, 0,  8'd0,  0, 0);
        // Full-range top bound, max FF, load FE
        step(1, 0, 0, 8'hFE, 8'hFF,   8'd8,  0, 0,  8'd0,  0, 0);
        step(0, 1, 0, 8'h00, 8'hFF,   8'hFE, 0, 0,  8'hFE, 0, 0);
        step(0, 1, 0, 8'h00, 8'hFF,   8'hFF, 1, 0,  8'hFF, 0 | 1, 0);
        step(0, 1, 0, 8'h00, 8'hFF,   8'h00, 0, 1,  8'hFF, 1, 0);
        step(0, 1, 0, 8'h00, 8'hFF,   8'h01, 0, 0,  8'hFF, 1, 0);
        step(0, 0, 0, 8'h00, 8'hFF,   8'h02, 0, 0,  8'hFF, 0, 0);
        // Load priority over enable, clamp 20 -> 12
        step(1, 1, 0, 8'd20, 8'd12,   8'h02, 0, 0,  8'hFF, 0, 0);
        step(0, 0, 0, 8'd0,  8'd12,   8'd12, 0, 0,  8'd12, 0, 0);
        // Out of range after max lowered: up
        step(1, 0, 0, 8'd40, 8'd50,   8'd12, 0, 0,  8'd12, 0, 0);
        step(0, 1, 0, 8'd0,  8'd10,   8'd40, 0, 0,  8'd40, 0, 0);
        step(0, 0, 0, 8'd0,  8'd10,   8'd0,  0, 0,  8'd10, 0, 0);
        // Out of range after max lowered: down
        step(1, 0, 0, 8'd40, 8'd50,   8'd0,  0, 0,  8'd10, 0, 0);
        step(0, 1, 1, 8'd0,  8'd10,   8'd40, 0, 0,  8'd40, 0, 0);
        step(0, 0, 1, 8'd0,  8'd10,   8'd10, 0, 0,  8'd10, 0, 0);
        // max 0: single-value range, every enabled step is terminal
        step(1, 0, 0, 8'd7,  8'd0,    8'd10, 0, 0,  8'd10, 0, 0);
        step(0, 1, 0, 8'd0,  8'd0,    8'd0,  1, 0,  8'd0,  1, 0);
        step(0, 1, 1, 8'd0,  8'd0,    8'd0,  1, 1,  8'd0,  1, 0);
        step(0, 0, 0, 8'd0,  8'd0,    8'd0,  0, 1,  8'd0,  0, 0);
        // Count at 8'h37 with a wrap pending, then reset mid-cycle
        step(1, 0, 0, 8'h37, 8'h37,   8'd0,  0, 0,  8'd0,  0, 0);
        step(0, 1, 0, 8'h00, 8'h37,   8'h37, 1, 0,  8'h37, 1, 0);

        // Edge after the last vector: wrap counter goes to 0 with wrap_o=1, sat holds 37.
        @(posedge Clk);
        #2;
        chk("pre_rst.wrap_o", 100, {7'd0, wrap_w}, 8'd1);
        chk("pre_rst.sat",    100, data_s, 8'h37);
        Rst_n = 1'b0;
        #1;
        chk("rst.wrap.data_o", 101, data_w, 8'h00);
        chk("rst.wrap.wrap_o", 101, {7'd0, wrap_w}, 8'd0);
        chk("rst.sat.data_o",  101, data_s, 8'h11);
        chk("rst.sat.wrap_o",  101, {7'd0, wrap_s}, 8'd0);
        // Reset dominates clock edges with load/enable active.
        load_i = 1'b1;
        data_i = 8'h22;
        max_i  = 8'hFF;
        @(posedge Clk);
        #1;
        chk("rst_hold.wrap.data_o", 102, data_w, 8'h00);
        chk("rst_hold.sat.data_o",  102, data_s, 8'h11);
        // First edge after release takes the load.
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;
        chk("post_rst.wrap.data_o", 103, data_w, 8'h22);
        chk("post_rst.sat.data_o",  103, data_s, 8'h22);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
